// File: rtl/da2_pkg.sv
// -----------------------------------------------------------------------------
// da2_pkg
// Shared types and constants for the Pmod DA2 serial transmitter.
//   state_t     : transmitter FSM states (IDLE, SHIFT, GAP)
//   FRAME_BITS  : bits per DAC frame
//   DATA_BITS   : bits per sample code
//   PD_NORMAL   : power-down field for normal operation
//   build_frame : assembles one 16-bit frame {00, pd, sample}
// -----------------------------------------------------------------------------
package da2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int         FRAME_BITS = 16;
    localparam int         DATA_BITS  = 12;
    localparam logic [1:0] PD_NORMAL  = 2'b00;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [1:0]           pd,
        input logic [DATA_BITS-1:0] sample
    );
        return {2'b00, pd, sample};
    endfunction

endpackage

// File: rtl/da2_sclk_gen.sv
// -----------------------------------------------------------------------------
// da2_sclk_gen
// Divides the system clock into the DAC serial clock. Each bit period is
// CLK_DIV cycles: SCLK high for the first half, low for the second half.
// While disabled the divider sits at the start of a period with SCLK high.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_en         run the divider (high while shifting)
//   o_sclk       registered serial clock level, idles high
//   o_bit_start  high in the first cycle of a bit period
//   o_bit_end    high in the last cycle of a bit period
// -----------------------------------------------------------------------------
module da2_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_bit_start,
    output logic o_bit_end
);

    localparam int            DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_next;

    always_comb begin
        w_div_next = '0;
        if (i_en && (r_div != LAST)) begin
            w_div_next = r_div + 1'b1;
        end
    end

    // SCLK is registered from the next divider value so the level lines up
    // with the divider position in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            o_sclk <= 1'b1;
        end else begin
            r_div  <= w_div_next;
            o_sclk <= (w_div_next < HALF);
        end
    end

    assign o_bit_start = i_en && (r_div == '0);
    assign o_bit_end   = i_en && (r_div == LAST);

endmodule

// File: rtl/pmod_da2_tx.sv
// -----------------------------------------------------------------------------
// pmod_da2_tx
// Two-channel serial transmitter for the 12-bit Pmod DAC. One sample pair is
// accepted per VALID/READY handshake, framed as {00, pd, sample} and shifted
// out MSB first on DINA/DINB under a shared active-low SYNC.
// Optional feature macro: DA2_PD_EN (adds i_pd; otherwise pd bits are 00).
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_sample_a  channel A code (unsigned, 12 bits)
//   i_sample_b  channel B code (unsigned, 12 bits)
//   i_pd        power-down bits (only with DA2_PD_EN)
//   i_valid     sample pair valid
//   o_ready     transmitter can accept a sample pair
//   o_sclk      serial clock, idles high
//   o_sync      frame select, active low
//   o_dina      serial data channel A
//   o_dinb      serial data channel B
//   o_done      one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module pmod_da2_tx
    import da2_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_sample_a,
    input  logic [DATA_BITS-1:0] i_sample_b,
`ifdef DA2_PD_EN
    input  logic [1:0]           i_pd,
`endif
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_sclk,
    output logic                 o_sync,
    output logic                 o_dina,
    output logic                 o_dinb,
    output logic                 o_done
);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [FRAME_BITS-1:0] r_sh_a;
    logic [FRAME_BITS-1:0] r_sh_b;
    logic [3:0]            r_bit_cnt;
    logic [GW-1:0]         r_gap_cnt;

    logic                  w_capture;
    logic                  w_last_bit;
    logic                  w_gap_done;
    logic                  w_sclk_en;
    logic                  w_bit_start;
    logic                  w_bit_end;
    logic [1:0]            w_pd;
    logic [FRAME_BITS-1:0] w_frame_a;
    logic [FRAME_BITS-1:0] w_frame_b;

`ifdef DA2_PD_EN
    assign w_pd = i_pd;
`else
    assign w_pd = PD_NORMAL;
`endif

    assign w_frame_a  = build_frame(w_pd, i_sample_a);
    assign w_frame_b  = build_frame(w_pd, i_sample_b);

    assign w_capture  = (r_state == IDLE) && i_valid;
    assign w_sclk_en  = (r_state == SHIFT);
    assign w_last_bit = w_bit_end && (r_bit_cnt == 4'd0);
    assign w_gap_done = (r_state == GAP) && (r_gap_cnt == GAP_LAST);
    assign o_ready    = (r_state == IDLE);

    da2_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (w_sclk_en),
        .o_sclk      (o_sclk),
        .o_bit_start (w_bit_start),
        .o_bit_end   (w_bit_end)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_capture)  w_state_next = SHIFT;
            SHIFT:   if (w_last_bit) w_state_next = GAP;
            GAP:     if (w_gap_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The DIN registers are loaded at the edge that opens a bit period
    // (bit_end of the previous one). The shift registers advance one cycle
    // later, on bit_start, so their MSB is already the next bit by then.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_bit_cnt <= 4'd0;
            o_sync    <= 1'b1;
            o_dina    <= 1'b0;
            o_dinb    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= w_last_bit;
            if (w_capture) begin
                r_sh_a    <= w_frame_a;
                r_sh_b    <= w_frame_b;
                o_dina    <= w_frame_a[FRAME_BITS-1];
                o_dinb    <= w_frame_b[FRAME_BITS-1];
                o_sync    <= 1'b0;
                r_bit_cnt <= 4'd15;
            end else if (r_state == SHIFT) begin
                if (w_bit_start) begin
                    r_sh_a <= {r_sh_a[FRAME_BITS-2:0], 1'b0};
                    r_sh_b <= {r_sh_b[FRAME_BITS-2:0], 1'b0};
                end
                if (w_bit_end) begin
                    if (r_bit_cnt == 4'd0) begin
                        o_sync <= 1'b1;
                        o_dina <= 1'b0;
                        o_dinb <= 1'b0;
                    end else begin
                        o_dina    <= r_sh_a[FRAME_BITS-1];
                        o_dinb    <= r_sh_b[FRAME_BITS-1];
                        r_bit_cnt <= r_bit_cnt - 4'd1;
                    end
                end
            end
        end
    end

    // The DONE cycle is the first GAP cycle, so the counter starts at zero there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == GAP) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end else begin
            r_gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pmod_da2_tx.sv
module tb_pmod_da2_tx;

    localparam int D = 4;
    localparam int G = 2;
`ifdef DA2_PD_EN
    localparam logic [1:0] PD_MASK = 2'b11;
`else
    localparam logic [1:0] PD_MASK = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sa;
    logic [11:0] sb;
    logic [1:0]  pd;
    logic        valid;
    logic        o_ready, o_sclk, o_sync, o_dina, o_dinb, o_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pmod_da2_tx #(
        .CLK_DIV    (D),
        .GAP_CYCLES (G)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sample_a (sa),
        .i_sample_b (sb),
`ifdef DA2_PD_EN
        .i_pd       (pd),
`endif
        .i_valid    (valid),
        .o_ready    (o_ready),
        .o_sclk     (o_sclk),
        .o_sync     (o_sync),
        .o_dina     (o_dina),
        .o_dinb     (o_dinb),
        .o_done     (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is 16 bits = pd*4096 + sample, sent MSB first.
    function automatic int model_frame(input logic [1:0] p, input logic [11:0] s);
        return int'(p & PD_MASK) * 4096 + int'(s);
    endfunction

    typedef struct {
        int fa;
        int fb;
        int done_cyc;
    } exp_t;

    exp_t q[$];

    int          cyc = 0;
    logic        prev_sync = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        prev_ready = 1'b1;
    logic [15:0] word_a, word_b;
    int          nbits = 0;
    int          sync_low = 0;
    int          sync_low_last = 0;
    int          sync_high = 0;
    int          sync_high_last = 0;
    int          ready_run = 0;
    int          ready_run_last = 0;
    int          frames_done = 0;

    // Observes the DAC pins the way the DAC does: data taken on SCLK falls
    // while SYNC is low; frame length and DONE timing against the capture cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_sync  = 1'b1;
            prev_sclk  = 1'b1;
            prev_ready = 1'b1;
            nbits      = 0;
            sync_low   = 0;
            sync_high  = 0;
            ready_run  = 0;
        end else begin
            exp_t e;
            cyc++;
            if (!o_sync) begin
                if (prev_sync) begin
                    sync_high_last = sync_high;
                    sync_high      = 0;
                    sync_low       = 0;
                    nbits          = 0;
                    word_a         = '0;
                    word_b         = '0;
                end
                sync_low++;
            end else begin
                if (!prev_sync) sync_low_last = sync_low;
                sync_high++;
            end
            if (o_ready) begin
                ready_run++;
            end else if (prev_ready) begin
                ready_run_last = ready_run;
                ready_run      = 0;
            end
            if (prev_sclk && !o_sclk && !o_sync) begin
                word_a = {word_a[14:0], o_dina};
                word_b = {word_b[14:0], o_dinb};
                nbits++;
            end
            if (o_done) begin
                chk("done_with_pending", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("dina_word", 32'(word_a), e.fa);
                    chk("dinb_word", 32'(word_b), e.fb);
                    chk("bit_count", nbits, 16);
                    chk("sync_low_len", sync_low_last, 16 * D);
                    frames_done++;
                end
            end
            if (valid && o_ready) begin
                e.fa       = model_frame(pd, sa);
                e.fb       = model_frame(pd, sb);
                e.done_cyc = cyc + 1 + 16 * D;
                q.push_back(e);
            end
            prev_sync  = o_sync;
            prev_sclk  = o_sclk;
            prev_ready = o_ready;
        end
    end

    // Returns #1 after the edge that captured the currently driven inputs.
    task automatic wait_capture();
        int t = 0;
        #1;
        while (!o_ready && t < 1000) begin
            @(posedge clk); #2;
            t++;
        end
        chk("capture_timeout", 32'(o_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] p);
        @(posedge clk); #1;
        sa = a; sb = b; pd = p; valid = 1'b1;
        wait_capture();
        valid = 1'b0;
        sa = 12'($urandom); sb = 12'($urandom); pd = 2'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(posedge clk); #2;
        while ((q.size() != 0 || !o_ready) && t < 2000) begin
            @(posedge clk); #2;
            t++;
        end
        chk("idle_timeout", 32'(q.size() == 0 && o_ready), 1);
    endtask

    initial begin
        int f0;
        rst_n = 1'b0; valid = 1'b0; sa = '0; sb = '0; pd = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_sync",  32'(o_sync),  1);
        chk("rst_sclk",  32'(o_sclk),  1);
        chk("rst_dina",  32'(o_dina),  0);
        chk("rst_dinb",  32'(o_dinb),  0);
        chk("rst_done",  32'(o_done),  0);
        rst_n = 1'b1;

        // Directed frame
        send(12'hABC, 12'h123, 2'b00);
        wait_idle();

        // Back-to-back with VALID held high
        @(posedge clk); #1;
        sa = 12'hFFF; sb = 12'($urandom); pd = 2'b00; valid = 1'b1;
        wait_capture();
        sa = 12'h000; sb = 12'($urandom);
        wait_capture();
        valid = 1'b0;
        wait_idle();
        chk("b2b_sync_high", sync_high_last, G + 1);
        chk("b2b_ready_high", ready_run_last, 1);

        // VALID pulsed mid-frame must be ignored
        f0 = frames_done;
        send(12'h5A5, 12'h0F0, 2'b00);
        repeat (20) @(posedge clk);
        #1; valid = 1'b1; sa = 12'h111; sb = 12'h222;
        @(posedge clk); #1; valid = 1'b0;
        wait_idle();
        chk("ignored_valid_frames", frames_done - f0, 1);

        // Reset after bit 8 has been sent
        send(12'hC3C, 12'h3C3, 2'b00);
        repeat (8 * D) @(posedge clk);
        #2;
        chk("pre_rst_sync", 32'(o_sync), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_sync",  32'(o_sync),  1);
        chk("midrst_sclk",  32'(o_sclk),  1);
        chk("midrst_ready", 32'(o_ready), 1);
        chk("midrst_dina",  32'(o_dina),  0);
        chk("midrst_done",  32'(o_done),  0);
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        send(12'h9E1, 12'h47D, 2'b00);
        wait_idle();

        // Power-down field (sent only when the feature is built in)
        send(12'h555, 12'hAAA, 2'b11);
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            send(12'($urandom), 12'($urandom), 2'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(2, 50)) @(posedge clk);
                #1; valid = 1'b1;
                @(posedge clk); #1; valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        wait_idle();
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
